// File: rtl/keypad_debouncer.sv
// Debounces a 4-digit keypad plus enter button and turns each qualified press
// into one strobe: digit accepted, compare request, or rejected press.
module keypad_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MAX_DIGITS      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key,
   input  logic       enter_key,
   output logic       input_value,
   output logic [1:0] bits,
   output logic       compare,
   output logic       key_error,
   output logic [3:0] digit_count
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]        MAX_DIG  = 4'(MAX_DIGITS);
   localparam logic [4:0]        ENTER_ONLY = 5'b10000;

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      FIRE,
      WAIT_REL,
      REL_DEBOUNCE
   } state_t;

   logic [4:0] raw;
   logic [4:0] sync1_reg;
   logic [4:0] sync2_reg;
   logic [4:0] v;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [4:0]       cap_reg, cap_next;
   logic [1:0]       bits_reg, bits_next;
   logic [3:0]       digit_count_reg, digit_count_next;
   logic             input_value_reg, input_value_next;
   logic             compare_reg, compare_next;
   logic             key_error_reg, key_error_next;

   logic             digit_one_hot;
   logic [1:0]       digit_idx;

   assign raw = {enter_key, key};
   assign v   = sync2_reg;

   // Two-flop synchronizer per raw button.
   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_sync
         always_ff @(posedge clk) begin
            if (reset) begin
               sync1_reg[gi] <= 1'b0;
               sync2_reg[gi] <= 1'b0;
            end else begin
               sync1_reg[gi] <= raw[gi];
               sync2_reg[gi] <= sync1_reg[gi];
            end
         end
      end
   endgenerate

   always_comb begin
      digit_one_hot = 1'b0;
      digit_idx     = 2'd0;
      case (cap_reg)
         5'b00001: begin digit_one_hot = 1'b1; digit_idx = 2'd0; end
         5'b00010: begin digit_one_hot = 1'b1; digit_idx = 2'd1; end
         5'b00100: begin digit_one_hot = 1'b1; digit_idx = 2'd2; end
         5'b01000: begin digit_one_hot = 1'b1; digit_idx = 2'd3; end
         default:  begin digit_one_hot = 1'b0; digit_idx = 2'd0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         cap_reg         <= '0;
         bits_reg        <= '0;
         digit_count_reg <= '0;
         input_value_reg <= 1'b0;
         compare_reg     <= 1'b0;
         key_error_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         cap_reg         <= cap_next;
         bits_reg        <= bits_next;
         digit_count_reg <= digit_count_next;
         input_value_reg <= input_value_next;
         compare_reg     <= compare_next;
         key_error_reg   <= key_error_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      cap_next         = cap_reg;
      bits_next        = bits_reg;
      digit_count_next = digit_count_reg;
      input_value_next = 1'b0;
      compare_next     = 1'b0;
      key_error_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (v != 5'd0) begin
               cap_next   = v;
               cnt_next   = '0;
               state_next = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            // Counter stops at its terminal value so it can never wrap.
            if (v != cap_reg)
               state_next = IDLE;
            else if (cnt_reg == CNT_LAST)
               state_next = FIRE;
            else
               cnt_next = cnt_reg + 1'b1;
         end
         FIRE: begin
            state_next = WAIT_REL;
            if (digit_one_hot && (digit_count_reg < MAX_DIG)) begin
               bits_next        = digit_idx;
               input_value_next = 1'b1;
               digit_count_next = digit_count_reg + 4'd1;
            end else if (cap_reg == ENTER_ONLY) begin
               compare_next     = 1'b1;
               digit_count_next = 4'd0;
            end else begin
               key_error_next = 1'b1;
            end
         end
         WAIT_REL: begin
            if (v == 5'd0) begin
               cnt_next   = '0;
               state_next = REL_DEBOUNCE;
            end
         end
         REL_DEBOUNCE: begin
            if (v != 5'd0)
               state_next = WAIT_REL;
            else if (cnt_reg == CNT_LAST)
               state_next = IDLE;
            else
               cnt_next = cnt_reg + 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign input_value = input_value_reg;
   assign bits        = bits_reg;
   assign compare     = compare_reg;
   assign key_error   = key_error_reg;
   assign digit_count = digit_count_reg;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with DEBOUNCE_CYCLES=4, MAX_DIGITS=2;
// strobes are tallied by a monitor and compared against hand-derived counts.
module tb_keypad_debouncer;

   logic       clk;
   logic       reset;
   logic [3:0] key;
   logic       enter_key;
   logic       input_value;
   logic [1:0] bits;
   logic       compare;
   logic       key_error;
   logic [3:0] digit_count;

   int checks   = 0;
   int failures = 0;

   int iv_cnt   = 0;
   int cmp_cnt  = 0;
   int err_cnt  = 0;
   int excl_cnt = 0;
   int dc_at_cmp     = -1;
   int dc_before_cmp = -1;
   int bits_at_cmp   = -1;
   int prev_dc       = 0;

   int iv0, cmp0, err0;

   keypad_debouncer #(
      .DEBOUNCE_CYCLES(4),
      .MAX_DIGITS     (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key        (key),
      .enter_key  (enter_key),
      .input_value(input_value),
      .bits       (bits),
      .compare    (compare),
      .key_error  (key_error),
      .digit_count(digit_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sampled 2 time units after each rising edge, away from stimulus changes.
   always @(posedge clk) begin
      #2;
      if (input_value === 1'b1) iv_cnt++;
      if (key_error === 1'b1) err_cnt++;
      if (compare === 1'b1) begin
         cmp_cnt++;
         dc_at_cmp     = int'(digit_count);
         dc_before_cmp = prev_dc;
         bits_at_cmp   = int'(bits);
      end
      if ((int'(input_value === 1'b1) + int'(compare === 1'b1) + int'(key_error === 1'b1)) > 1)
         excl_cnt++;
      prev_dc = int'(digit_count);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s got=%0d", tag, got);
      end
   endtask

   task automatic snap();
      iv0  = iv_cnt;
      cmp0 = cmp_cnt;
      err0 = err_cnt;
   endtask

   task automatic press(input logic [4:0] k, input int hold);
      @(negedge clk);
      {enter_key, key} = k;
      repeat (hold) @(negedge clk);
      {enter_key, key} = 5'd0;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      key       = 4'd0;
      enter_key = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_input_value", input_value, 0);
      check("rst_compare", compare, 0);
      check("rst_key_error", key_error, 0);
      check("rst_bits", bits, 0);
      check("rst_digit_count", digit_count, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Hold key[2]: strobe on the 8th edge counting the first sampling edge.
      snap();
      @(negedge clk);
      key = 4'b0100;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("lat_iv_edge%0d", i), input_value, (i == 8) ? 1 : 0);
         if (i == 8) begin
            check("lat_bits", bits, 2);
            check("lat_digit_count", digit_count, 1);
         end
      end
      repeat (8) @(negedge clk);
      key = 4'd0;
      repeat (20) @(negedge clk);
      check("hold_single_strobe", iv_cnt - iv0, 1);

      // Chord of key[0] and key[3].
      snap();
      press(5'b01001, 12);
      check("chord_err", err_cnt - err0, 1);
      check("chord_iv", iv_cnt - iv0, 0);
      check("chord_bits", bits, 2);
      check("chord_digit_count", digit_count, 1);

      // Enter alone clears the count.
      snap();
      press(5'b10000, 12);
      check("enter_cmp", cmp_cnt - cmp0, 1);
      check("enter_dc_at_cmp", dc_at_cmp, 0);
      check("enter_bits", bits, 2);

      // key[1] bounce: 3 high, 1 low, then held.
      snap();
      @(negedge clk);
      key = 4'b0010;
      repeat (3) @(negedge clk);
      key = 4'd0;
      @(negedge clk);
      key = 4'b0010;
      repeat (12) @(negedge clk);
      key = 4'd0;
      repeat (20) @(negedge clk);
      check("bounce_iv", iv_cnt - iv0, 1);
      check("bounce_bits", bits, 1);
      check("bounce_digit_count", digit_count, 1);

      // 3-cycle glitch produces nothing.
      snap();
      press(5'b00010, 3);
      check("glitch_iv", iv_cnt - iv0, 0);
      check("glitch_err", err_cnt - err0, 0);
      check("glitch_digit_count", digit_count, 1);

      // Overflow at MAX_DIGITS=2.
      press(5'b10000, 12);
      snap();
      press(5'b00001, 12);
      press(5'b00010, 12);
      press(5'b00100, 12);
      check("ovf_iv", iv_cnt - iv0, 2);
      check("ovf_err", err_cnt - err0, 1);
      check("ovf_digit_count", digit_count, 2);
      check("ovf_bits", bits, 1);

      // Digits 3,1 then enter.
      press(5'b10000, 12);
      press(5'b01000, 12);
      check("code_bits3", bits, 3);
      press(5'b00010, 12);
      check("code_digit_count", digit_count, 2);
      snap();
      press(5'b10000, 12);
      check("code_cmp", cmp_cnt - cmp0, 1);
      check("code_dc_before", dc_before_cmp, 2);
      check("code_dc_at_cmp", dc_at_cmp, 0);
      check("code_bits_at_cmp", bits_at_cmp, 1);
      check("code_bits_after", bits, 1);

      // Reset mid-debounce with key[2] held, then a fresh full debounce.
      snap();
      @(negedge clk);
      key = 4'b0100;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid_iv", iv_cnt - iv0, 0);
      check("rst_mid_digit_count", digit_count, 0);
      check("rst_mid_bits", bits, 0);
      reset = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_lat_iv_edge%0d", i), input_value, (i == 8) ? 1 : 0);
      end
      repeat (6) @(negedge clk);
      key = 4'd0;
      repeat (20) @(negedge clk);
      check("rst_after_iv", iv_cnt - iv0, 1);
      check("rst_after_bits", bits, 2);
      check("rst_after_digit_count", digit_count, 1);

      check("strobes_exclusive", excl_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_debouncer.md
KEYPAD_DEBOUNCER -- requirements
Module: keypad_debouncer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive stable cycles that qualify a press or release (legal range 2..65535).
REQ-002 Parameter: MAX_DIGITS, default 8, maximum digits accepted per code entry (legal range 1..15).
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset; synchronous and active-high.
REQ-005 Port: key  input  4  raw, asynchronous, active-high digit buttons; key[i] encodes digit value i.
REQ-006 Port: enter_key  input  1  raw, asynchronous, active-high enter button.
REQ-007 Port: input_value  output  1  one-cycle strobe marking a new accepted digit on bits.
REQ-008 Port: bits  output  2  encoded digit value; valid during input_value and held until the next accepted digit.
REQ-009 Port: compare  output  1  one-cycle strobe requesting comparison of the entered code.
REQ-010 Port: key_error  output  1  one-cycle strobe for a rejected press (chord or digit overflow).
REQ-011 Port: digit_count  output  4  number of digits accepted since the last compare or reset.

Function
REQ-012 The five raw inputs shall each pass through a two-flop synchronizer; the vector v = {enter_key, key[3:0]} used below is the synchronized value.
REQ-013 The FSM shall have exactly five states: IDLE, DEBOUNCE, FIRE, WAIT_REL, REL_DEBOUNCE.
REQ-014 IDLE: when v != 0, capture v into cap, clear the cycle counter, and go to DEBOUNCE; otherwise remain in IDLE.
REQ-015 DEBOUNCE: when v != cap, return to IDLE; otherwise increment the counter, and go to FIRE on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-016 FIRE: lasts exactly one cycle, then goes to WAIT_REL; the action is selected by cap per REQ-017..REQ-019.
REQ-017 cap is one-hot in key[3:0] and digit_count < MAX_DIGITS: register bits = index of the set key, pulse input_value, and increment digit_count.
REQ-018 cap == enter only: pulse compare and clear digit_count to 0 in the same cycle; bits is unchanged.
REQ-019 Any other cap (two or more keys, enter with a digit, or digit while digit_count == MAX_DIGITS): pulse key_error only; bits and digit_count are unchanged.
REQ-020 WAIT_REL: when v == 0, clear the counter and go to REL_DEBOUNCE.
REQ-021 REL_DEBOUNCE: when v != 0, return to WAIT_REL; otherwise count, and go to IDLE on reaching DEBOUNCE_CYCLES-1.
REQ-022 Holding keys shall never produce more than one strobe per press, and adding keys while held shall have no effect.
REQ-023 All outputs shall be registered; input_value, compare and key_error are mutually exclusive and each is high for at most one cycle per press.
REQ-024 Latency: the strobe shall assert exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples a stable raw press.
REQ-025 The counter shall be wide enough for DEBOUNCE_CYCLES-1 and shall never wrap.
REQ-026 Press glitches shorter than DEBOUNCE_CYCLES produce no strobe; release glitches shorter than DEBOUNCE_CYCLES do not re-arm the FSM.

Reset
REQ-027 While reset is high at a clock edge: FSM = IDLE; counter, cap, synchronizers, bits and digit_count = 0; input_value, compare and key_error = 0.
REQ-028 Reset asserted mid-debounce or mid-hold shall abort without any strobe; a key still held after reset releases shall be treated as a new press.

Verification
REQ-029 DEBOUNCE_CYCLES=4: hold key[2] for 20 cycles -> exactly one input_value pulse, 8 edges after the first sampling edge, with bits=2 and digit_count=1.
REQ-030 key[1] bouncing as 3 cycles high, 1 low, then held -> a single strobe with bits=1; a 3-cycle-only pulse -> no strobe.
REQ-031 key[0] and key[3] pressed together -> key_error pulse only; bits and digit_count unchanged.
REQ-032 MAX_DIGITS=2, three digit presses -> two input_value pulses, then key_error; digit_count stays at 2.
REQ-033 Digits 3,1 then enter -> compare pulse and digit_count 2->0 in the same cycle; bits stays 1.
REQ-034 Reset during DEBOUNCE with the key held -> no strobe during reset; after release of reset, a full debounce and then one strobe.
